// File: rtl/sb_sched_pkg.sv
// Shared types for the sideband transaction scheduler: FSM states and the
// trans_sel encoding understood by the transactions generator and link control unit.
package sb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } sched_state_e;

    typedef enum logic [2:0] {
        TS_NONE   = 3'd0,
        TS_AT_CMD = 3'd2,
        TS_AT_RSP = 3'd3,
        TS_LT     = 3'd4
    } trans_sel_e;

endpackage

// File: rtl/sb_timeout_cnt.sv
// Saturating timeout counter: clear forces zero, enable counts up to MAX and holds;
// expired is high while the count sits at MAX.
module sb_timeout_cnt #(
    parameter int MAX = 255
) (
    input  logic sb_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(MAX));

endmodule

// File: rtl/sb_trans_scheduler.sv
// Sideband transaction scheduler: arbitrates AT response / LT / AT command requests and
// tracks the outstanding AT command. Define SB_AT_RETRY_EN to re-send on response timeout.
module sb_trans_scheduler
    import sb_sched_pkg::*;
#(
    parameter int BUSY_TO   = 255,
    parameter int RSP_TO    = 1000,
    parameter int MAX_RETRY = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       lt_req,
    input  logic       at_cmd_req,
    input  logic [7:0] at_cmd_addr,
    input  logic       at_rsp_req,
    input  logic [7:0] at_rsp_addr,
    input  logic       at_rsp_rcvd,
    input  logic       trans_sent,
    input  logic       disconnected_s,
    output logic [2:0] trans_sel,
    output logic [7:0] control_unit_data,
    output logic       lt_done,
    output logic       at_cmd_done,
    output logic       at_rsp_done,
    output logic       at_cmd_err,
    output logic       busy_err,
    output logic       sched_busy
);

`ifdef SB_AT_RETRY_EN
    localparam bit RETRY_ENABLED = 1'b1;
`else
    localparam bit RETRY_ENABLED = 1'b0;
`endif
    // With retry disabled the limit collapses to zero, so the first timeout is fatal.
    localparam int RETRY_LIMIT = RETRY_ENABLED ? MAX_RETRY : 0;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    sched_state_e   state_q, state_d;
    trans_sel_e     trans_sel_q, trans_sel_d;
    trans_sel_e     owner_q, owner_d;
    logic [7:0]     data_q, data_d;
    logic [7:0]     cmd_addr_q, cmd_addr_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           outstanding_q, outstanding_d;
    logic           lt_done_q, lt_done_d;
    logic           at_cmd_done_q, at_cmd_done_d;
    logic           at_rsp_done_q, at_rsp_done_d;
    logic           at_cmd_err_q, at_cmd_err_d;
    logic           busy_err_q, busy_err_d;
    logic           sched_busy_q, sched_busy_d;
    logic           busy_expired;
    logic           rsp_expired;

    sb_timeout_cnt #(.MAX(BUSY_TO)) u_busy_to (
        .sb_clk  (sb_clk),
        .rst     (rst),
        .clear   ((state_q != BUSY) || disconnected_s),
        .enable  (state_q == BUSY),
        .expired (busy_expired)
    );

    sb_timeout_cnt #(.MAX(RSP_TO)) u_rsp_to (
        .sb_clk  (sb_clk),
        .rst     (rst),
        .clear   (!outstanding_q || disconnected_s),
        .enable  (outstanding_q),
        .expired (rsp_expired)
    );

    always_comb begin
        state_d       = state_q;
        trans_sel_d   = TS_NONE;
        owner_d       = owner_q;
        data_d        = data_q;
        cmd_addr_d    = cmd_addr_q;
        gap_d         = gap_q;
        retry_d       = retry_q;
        outstanding_d = outstanding_q;
        lt_done_d     = 1'b0;
        at_cmd_done_d = 1'b0;
        at_rsp_done_d = 1'b0;
        at_cmd_err_d  = 1'b0;
        busy_err_d    = 1'b0;

        // Response tracking runs alongside the FSM; a response beats a same-cycle timeout.
        if (outstanding_q) begin
            if (at_rsp_rcvd) begin
                at_cmd_done_d = 1'b1;
                outstanding_d = 1'b0;
                retry_d       = '0;
            end else if (rsp_expired) begin
                outstanding_d = 1'b0;
                if (retry_q != RW'(RETRY_LIMIT)) begin
                    retry_d = retry_q + RW'(1);
                end else begin
                    at_cmd_err_d = 1'b1;
                    retry_d      = '0;
                end
            end
        end else if (!at_cmd_req) begin
            retry_d = '0;
        end

        case (state_q)
            IDLE: begin
                // Done/err pulses still visible this cycle mask the requester that has not yet dropped.
                if (!disconnected_s) begin
                    if (at_rsp_req && !at_rsp_done_q) begin
                        state_d     = ISSUE;
                        trans_sel_d = TS_AT_RSP;
                        owner_d     = TS_AT_RSP;
                        data_d      = at_rsp_addr;
                    end else if (lt_req && !lt_done_q) begin
                        state_d     = ISSUE;
                        trans_sel_d = TS_LT;
                        owner_d     = TS_LT;
                        data_d      = 8'h00;
                    end else if (at_cmd_req && !outstanding_q && !at_cmd_done_q && !at_cmd_err_q) begin
                        state_d     = ISSUE;
                        trans_sel_d = TS_AT_CMD;
                        owner_d     = TS_AT_CMD;
                        data_d      = (retry_q != '0) ? cmd_addr_q : at_cmd_addr;
                        cmd_addr_d  = data_d;
                    end
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (trans_sent || busy_expired) begin
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    gap_d   = '0;
                    if (trans_sent) begin
                        case (owner_q)
                            TS_LT:     lt_done_d     = 1'b1;
                            TS_AT_RSP: at_rsp_done_d = 1'b1;
                            TS_AT_CMD: outstanding_d = 1'b1;
                            default:   ;
                        endcase
                    end else begin
                        busy_err_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (disconnected_s) begin
            state_d       = IDLE;
            trans_sel_d   = TS_NONE;
            outstanding_d = 1'b0;
            retry_d       = '0;
            lt_done_d     = 1'b0;
            at_cmd_done_d = 1'b0;
            at_rsp_done_d = 1'b0;
            at_cmd_err_d  = 1'b0;
            busy_err_d    = 1'b0;
        end

        sched_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            trans_sel_q   <= TS_NONE;
            owner_q       <= TS_NONE;
            data_q        <= 8'h00;
            cmd_addr_q    <= 8'h00;
            gap_q         <= '0;
            retry_q       <= '0;
            outstanding_q <= 1'b0;
            lt_done_q     <= 1'b0;
            at_cmd_done_q <= 1'b0;
            at_rsp_done_q <= 1'b0;
            at_cmd_err_q  <= 1'b0;
            busy_err_q    <= 1'b0;
            sched_busy_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            trans_sel_q   <= trans_sel_d;
            owner_q       <= owner_d;
            data_q        <= data_d;
            cmd_addr_q    <= cmd_addr_d;
            gap_q         <= gap_d;
            retry_q       <= retry_d;
            outstanding_q <= outstanding_d;
            lt_done_q     <= lt_done_d;
            at_cmd_done_q <= at_cmd_done_d;
            at_rsp_done_q <= at_rsp_done_d;
            at_cmd_err_q  <= at_cmd_err_d;
            busy_err_q    <= busy_err_d;
            sched_busy_q  <= sched_busy_d;
        end
    end

    assign trans_sel         = trans_sel_q;
    assign control_unit_data = data_q;
    assign lt_done           = lt_done_q;
    assign at_cmd_done       = at_cmd_done_q;
    assign at_rsp_done       = at_rsp_done_q;
    assign at_cmd_err        = at_cmd_err_q;
    assign busy_err          = busy_err_q;
    assign sched_busy        = sched_busy_q;

endmodule

// File: tb/tb_sb_trans_scheduler.sv
// Directed bench for sb_trans_scheduler with default parameters; expects three command
// sends before at_cmd_err when SB_AT_RETRY_EN is defined, one otherwise.
module tb_sb_trans_scheduler;

    localparam int BUSY_TO = 255;
    localparam int RSP_TO  = 1000;
`ifdef SB_AT_RETRY_EN
    localparam int EXP_SENDS = 3;
`else
    localparam int EXP_SENDS = 1;
`endif

    logic       sb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       lt_req = 1'b0;
    logic       at_cmd_req = 1'b0;
    logic [7:0] at_cmd_addr = 8'h00;
    logic       at_rsp_req = 1'b0;
    logic [7:0] at_rsp_addr = 8'h00;
    logic       at_rsp_rcvd = 1'b0;
    logic       trans_sent = 1'b0;
    logic       disconnected_s = 1'b0;
    logic [2:0] trans_sel;
    logic [7:0] control_unit_data;
    logic       lt_done, at_cmd_done, at_rsp_done, at_cmd_err, busy_err, sched_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sb_trans_scheduler dut (
        .sb_clk            (sb_clk),
        .rst               (rst),
        .lt_req            (lt_req),
        .at_cmd_req        (at_cmd_req),
        .at_cmd_addr       (at_cmd_addr),
        .at_rsp_req        (at_rsp_req),
        .at_rsp_addr       (at_rsp_addr),
        .at_rsp_rcvd       (at_rsp_rcvd),
        .trans_sent        (trans_sent),
        .disconnected_s    (disconnected_s),
        .trans_sel         (trans_sel),
        .control_unit_data (control_unit_data),
        .lt_done           (lt_done),
        .at_cmd_done       (at_cmd_done),
        .at_rsp_done       (at_rsp_done),
        .at_cmd_err        (at_cmd_err),
        .busy_err          (busy_err),
        .sched_busy        (sched_busy)
    );

    always #5 sb_clk = ~sb_clk;

    task automatic tick();
        @(posedge sb_clk);
        #1;
        cyc++;
    endtask

    task automatic wait_sel(input logic [2:0] code, input int max_cyc, output int n, output bit ok);
        n = 0;
        while (trans_sel !== code && n < max_cyc) begin
            tick();
            n++;
        end
        ok = (trans_sel === code);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        tick();
        tick();
        checks++;
        if (trans_sel !== 3'd0) begin errors++; $display("FAIL reset_trans_sel: got %0d expected 0", trans_sel); end
        checks++;
        if (control_unit_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", control_unit_data); end
        checks++;
        if ({lt_done, at_cmd_done, at_rsp_done, at_cmd_err, busy_err} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 00000", {lt_done, at_cmd_done, at_rsp_done, at_cmd_err, busy_err});
        end
        checks++;
        if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sched_busy); end
        rst = 1'b1;
        tick();
        checks++;
        if (sched_busy !== 1'b0 || trans_sel !== 3'd0) begin
            errors++; $display("FAIL post_reset_idle: busy=%b sel=%0d expected 0/0", sched_busy, trans_sel);
        end
        $display("reset: done");
    endtask

    task automatic test_idle_ignore();
        trans_sent  = 1'b1;
        at_rsp_rcvd = 1'b1;
        tick();
        trans_sent  = 1'b0;
        at_rsp_rcvd = 1'b0;
        tick();
        checks++;
        if ({lt_done, at_cmd_done, at_rsp_done, at_cmd_err, busy_err, sched_busy} !== 6'b0) begin
            errors++; $display("FAIL idle_ignore: got %b expected 000000",
                               {lt_done, at_cmd_done, at_rsp_done, at_cmd_err, busy_err, sched_busy});
        end
        $display("idle_ignore: stray trans_sent/at_rsp_rcvd");
    endtask

    task automatic test_priority_cmd_rsp();
        int  n;
        bit  ok;
        bit  flag;
        int  t0;
        at_rsp_addr = 8'h5A;
        at_cmd_addr = 8'h0C;
        at_rsp_req  = 1'b1;
        at_cmd_req  = 1'b1;
        tick();
        checks++;
        if (trans_sel !== 3'd3) begin errors++; $display("FAIL prio_first_sel: got %0d expected 3", trans_sel); end
        checks++;
        if (control_unit_data !== 8'h5A) begin errors++; $display("FAIL prio_rsp_data: got %h expected 5a", control_unit_data); end
        tick();
        tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        checks++;
        if (at_rsp_done !== 1'b1) begin errors++; $display("FAIL rsp_done: got %b expected 1", at_rsp_done); end
        at_rsp_req = 1'b0;
        $display("priority: at_rsp served first");
        wait_sel(3'd2, 10, n, ok);
        checks++;
        if (!ok || n != 3) begin errors++; $display("FAIL cmd_after_gap: found=%0d latency=%0d expected 1/3", ok, n); end
        checks++;
        if (control_unit_data !== 8'h0C) begin errors++; $display("FAIL cmd_data: got %h expected 0c", control_unit_data); end
        flag = 1'b1;
        repeat (5) begin
            tick();
            if (control_unit_data !== 8'h0C) flag = 1'b0;
        end
        checks++;
        if (!flag) begin errors++; $display("FAIL cmd_data_held: got %h expected 0c", control_unit_data); end
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        t0 = cyc;
        checks++;
        if (at_cmd_done !== 1'b0) begin errors++; $display("FAIL cmd_done_early: got %b expected 0", at_cmd_done); end
        $display("priority: at_cmd sent, awaiting response");
        repeat (10) tick();
        lt_req = 1'b1;
        wait_sel(3'd4, 10, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lt_while_outstanding: got sel %0d expected 4", trans_sel); end
        checks++;
        if (control_unit_data !== 8'h00) begin errors++; $display("FAIL lt_data: got %h expected 00", control_unit_data); end
        tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        checks++;
        if (lt_done !== 1'b1) begin errors++; $display("FAIL lt_done_meanwhile: got %b expected 1", lt_done); end
        lt_req = 1'b0;
        while (cyc - t0 < 299) tick();
        at_rsp_rcvd = 1'b1;
        tick();
        at_rsp_rcvd = 1'b0;
        checks++;
        if (at_cmd_done !== 1'b1) begin errors++; $display("FAIL cmd_done: got %b expected 1 at +%0d", at_cmd_done, cyc - t0); end
        at_cmd_req = 1'b0;
        tick();
        flag = (at_cmd_done === 1'b0);
        repeat (4) begin
            if (trans_sel !== 3'd0) flag = 1'b0;
            tick();
        end
        checks++;
        if (!flag) begin errors++; $display("FAIL cmd_done_once: done=%b sel=%0d expected 0/0", at_cmd_done, trans_sel); end
        $display("priority: at_cmd_done after 300 cycles");
    endtask

    task automatic test_lt();
        lt_req = 1'b1;
        tick();
        checks++;
        if (trans_sel !== 3'd4) begin errors++; $display("FAIL lt_sel: got %0d expected 4", trans_sel); end
        tick();
        checks++;
        if (trans_sel !== 3'd0 || sched_busy !== 1'b1) begin
            errors++; $display("FAIL lt_sel_pulse: sel=%0d busy=%b expected 0/1", trans_sel, sched_busy);
        end
        repeat (18) tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        checks++;
        if (lt_done !== 1'b1 || sched_busy !== 1'b1) begin
            errors++; $display("FAIL lt_done: done=%b busy=%b expected 1/1", lt_done, sched_busy);
        end
        lt_req = 1'b0;
        tick();
        checks++;
        if (lt_done !== 1'b0 || sched_busy !== 1'b1) begin
            errors++; $display("FAIL lt_gap: done=%b busy=%b expected 0/1", lt_done, sched_busy);
        end
        tick();
        checks++;
        if (sched_busy !== 1'b0) begin errors++; $display("FAIL lt_idle: busy=%b expected 0", sched_busy); end
        $display("lt: served, gap 2, idle");
    endtask

    task automatic test_rsp_timeout();
        int sends;
        int n;
        int guard;
        at_cmd_addr = 8'h33;
        at_cmd_req  = 1'b1;
        sends = 0;
        n     = 0;
        guard = 0;
        while (at_cmd_err !== 1'b1 && guard < 5000) begin
            if (trans_sel === 3'd2) begin
                sends++;
                checks++;
                if (control_unit_data !== 8'h33) begin
                    errors++; $display("FAIL retry_addr: send %0d got %h expected 33", sends, control_unit_data);
                end
                at_cmd_addr = 8'h77;
                tick();
                trans_sent = 1'b1;
                tick();
                trans_sent = 1'b0;
                n = 0;
                guard += 2;
            end else begin
                tick();
                n++;
                guard++;
            end
        end
        checks++;
        if (at_cmd_err !== 1'b1) begin errors++; $display("FAIL cmd_err_seen: got %b expected 1", at_cmd_err); end
        checks++;
        if (sends != EXP_SENDS) begin errors++; $display("FAIL cmd_sends: got %0d expected %0d", sends, EXP_SENDS); end
        checks++;
        if (n != RSP_TO + 1) begin errors++; $display("FAIL rsp_timeout_latency: got %0d expected %0d", n, RSP_TO + 1); end
        at_cmd_req = 1'b0;
        tick();
        checks++;
        if (at_cmd_err !== 1'b0 || trans_sel !== 3'd0) begin
            errors++; $display("FAIL cmd_err_pulse: err=%b sel=%0d expected 0/0", at_cmd_err, trans_sel);
        end
        $display("rsp_timeout: %0d sends then at_cmd_err", sends);
    endtask

    task automatic test_busy_timeout();
        int n;
        bit saw_done;
        lt_req = 1'b1;
        tick();
        checks++;
        if (trans_sel !== 3'd4) begin errors++; $display("FAIL busy_to_sel: got %0d expected 4", trans_sel); end
        n = 0;
        saw_done = 1'b0;
        while (busy_err !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (lt_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (n != BUSY_TO + 2) begin errors++; $display("FAIL busy_err_latency: got %0d expected %0d", n, BUSY_TO + 2); end
        checks++;
        if (saw_done) begin errors++; $display("FAIL busy_no_done: got lt_done expected none"); end
        lt_req = 1'b0;
        tick();
        tick();
        checks++;
        if (sched_busy !== 1'b0 || busy_err !== 1'b0) begin
            errors++; $display("FAIL busy_to_idle: busy=%b err=%b expected 0/0", sched_busy, busy_err);
        end
        $display("busy_timeout: busy_err after %0d cycles", n);
    endtask

    task automatic test_disconnect();
        int n;
        bit ok;
        bit quiet;
        at_cmd_addr = 8'h44;
        at_cmd_req  = 1'b1;
        wait_sel(3'd2, 10, n, ok);
        tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        lt_req = 1'b1;
        wait_sel(3'd4, 10, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL disc_lt_grant: got sel %0d expected 4", trans_sel); end
        tick();
        disconnected_s = 1'b1;
        tick();
        checks++;
        if (sched_busy !== 1'b0 || trans_sel !== 3'd0) begin
            errors++; $display("FAIL disc_idle: busy=%b sel=%0d expected 0/0", sched_busy, trans_sel);
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            at_rsp_rcvd = (i == 0);
            trans_sent  = (i == 1);
            tick();
            if (trans_sel !== 3'd0 || sched_busy !== 1'b0 ||
                {lt_done, at_cmd_done, at_rsp_done, at_cmd_err, busy_err} !== 5'b0) quiet = 1'b0;
        end
        at_rsp_rcvd = 1'b0;
        trans_sent  = 1'b0;
        checks++;
        if (!quiet) begin errors++; $display("FAIL disc_quiet: activity seen while disconnected expected none"); end
        disconnected_s = 1'b0;
        tick();
        checks++;
        if (trans_sel !== 3'd4) begin errors++; $display("FAIL disc_release_sel: got %0d expected 4", trans_sel); end
        tick();
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        checks++;
        if (lt_done !== 1'b1) begin errors++; $display("FAIL disc_lt_done: got %b expected 1", lt_done); end
        lt_req = 1'b0;
        wait_sel(3'd2, 10, n, ok);
        checks++;
        if (!ok || control_unit_data !== 8'h44) begin
            errors++; $display("FAIL disc_cmd_reissue: sel=%0d data=%h expected 2/44", trans_sel, control_unit_data);
        end
        tick();
        trans_sent = 1'b1;
        tick();
        trans_sent  = 1'b0;
        at_rsp_rcvd = 1'b1;
        tick();
        at_rsp_rcvd = 1'b0;
        checks++;
        if (at_cmd_done !== 1'b1) begin errors++; $display("FAIL disc_cmd_done: got %b expected 1", at_cmd_done); end
        at_cmd_req = 1'b0;
        tick();
        $display("disconnect: cleared, regrants after release");
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_priority_cmd_rsp();
        test_lt();
        test_rsp_timeout();
        test_busy_timeout();
        test_disconnect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
